// File: rtl/morse_keyer_if.sv
// Character handshake between the UART receive path and the Morse keyer.
// The source drives ascii_in/in_valid; the keyer answers with in_ready.
interface morse_keyer_if;
  logic [6:0] ascii_in;
  logic       in_valid;
  logic       in_ready;

  modport master (output ascii_in, output in_valid, input in_ready);
  modport slave  (input ascii_in, input in_valid, output in_ready);
endinterface

// File: rtl/morse_keyer.sv
// Timed Morse keyer: accepts ASCII characters, looks up their code and drives the key line.
// Define MORSE_PUNCT_EN to add . , ? / = (6-element code storage) to the lookup table.
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES    = 2400000,
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 4
) (
  input  logic          clk_24,
  input  logic          rst,
  morse_keyer_if.slave  in_if,
  output logic          key,
  output logic          busy,
  output logic          bad_char
);

`ifdef MORSE_PUNCT_EN
  localparam int unsigned CODE_W = 6;
`else
  localparam int unsigned CODE_W = 5;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_MARK, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [6:0]        char_q, char_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        unit_q, unit_d;
  logic [2:0]        target_q, target_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              key_q, key_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              bad_q, bad_d;

  logic [6:0]        uc;
  logic [5:0]        dec_code;
  logic [2:0]        dec_len;
  logic              dec_ok;
  logic              dec_space;
  logic              tick;
  logic              phase_done;

  // Code table: bit0 is the first element, 1 = dash.
  always_comb begin
    uc = char_q;
    if (char_q >= 7'h61 && char_q <= 7'h7A) uc = char_q - 7'd32;
    dec_code  = '0;
    dec_len   = '0;
    dec_ok    = 1'b1;
    dec_space = 1'b0;
    case (uc)
      7'h20: dec_space = 1'b1;
      7'h41: {dec_len, dec_code} = {3'd2, 6'b000010};
      7'h42: {dec_len, dec_code} = {3'd4, 6'b000001};
      7'h43: {dec_len, dec_code} = {3'd4, 6'b000101};
      7'h44: {dec_len, dec_code} = {3'd3, 6'b000001};
      7'h45: {dec_len, dec_code} = {3'd1, 6'b000000};
      7'h46: {dec_len, dec_code} = {3'd4, 6'b000100};
      7'h47: {dec_len, dec_code} = {3'd3, 6'b000011};
      7'h48: {dec_len, dec_code} = {3'd4, 6'b000000};
      7'h49: {dec_len, dec_code} = {3'd2, 6'b000000};
      7'h4A: {dec_len, dec_code} = {3'd4, 6'b001110};
      7'h4B: {dec_len, dec_code} = {3'd3, 6'b000101};
      7'h4C: {dec_len, dec_code} = {3'd4, 6'b000010};
      7'h4D: {dec_len, dec_code} = {3'd2, 6'b000011};
      7'h4E: {dec_len, dec_code} = {3'd2, 6'b000001};
      7'h4F: {dec_len, dec_code} = {3'd3, 6'b000111};
      7'h50: {dec_len, dec_code} = {3'd4, 6'b000110};
      7'h51: {dec_len, dec_code} = {3'd4, 6'b001011};
      7'h52: {dec_len, dec_code} = {3'd3, 6'b000010};
      7'h53: {dec_len, dec_code} = {3'd3, 6'b000000};
      7'h54: {dec_len, dec_code} = {3'd1, 6'b000001};
      7'h55: {dec_len, dec_code} = {3'd3, 6'b000100};
      7'h56: {dec_len, dec_code} = {3'd4, 6'b001000};
      7'h57: {dec_len, dec_code} = {3'd3, 6'b000110};
      7'h58: {dec_len, dec_code} = {3'd4, 6'b001001};
      7'h59: {dec_len, dec_code} = {3'd4, 6'b001101};
      7'h5A: {dec_len, dec_code} = {3'd4, 6'b000011};
      7'h30: {dec_len, dec_code} = {3'd5, 6'b011111};
      7'h31: {dec_len, dec_code} = {3'd5, 6'b011110};
      7'h32: {dec_len, dec_code} = {3'd5, 6'b011100};
      7'h33: {dec_len, dec_code} = {3'd5, 6'b011000};
      7'h34: {dec_len, dec_code} = {3'd5, 6'b010000};
      7'h35: {dec_len, dec_code} = {3'd5, 6'b000000};
      7'h36: {dec_len, dec_code} = {3'd5, 6'b000001};
      7'h37: {dec_len, dec_code} = {3'd5, 6'b000011};
      7'h38: {dec_len, dec_code} = {3'd5, 6'b000111};
      7'h39: {dec_len, dec_code} = {3'd5, 6'b001111};
`ifdef MORSE_PUNCT_EN
      7'h2E: {dec_len, dec_code} = {3'd6, 6'b101010};
      7'h2C: {dec_len, dec_code} = {3'd6, 6'b110011};
      7'h3F: {dec_len, dec_code} = {3'd6, 6'b001100};
      7'h2F: {dec_len, dec_code} = {3'd5, 6'b001001};
      7'h3D: {dec_len, dec_code} = {3'd5, 6'b010001};
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  assign tick       = (cyc_q == CNT_W'(UNIT_CYCLES - 1));
  assign phase_done = tick && ((unit_q + 3'd1) == target_q);

  // Next-state and registered-output logic; counters restart on every phase entry.
  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    code_d   = code_q;
    len_d    = len_q;
    idx_d    = idx_q;
    target_d = target_q;
    bad_d    = 1'b0;
    cyc_d    = tick ? '0 : cyc_q + CNT_W'(1);
    unit_d   = tick ? unit_q + 3'd1 : unit_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        unit_d = '0;
        if (in_if.in_valid && rdy_q) begin
          char_d  = in_if.ascii_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cyc_d  = '0;
        unit_d = '0;
        idx_d  = '0;
        if (dec_space) begin
          len_d    = '0;
          target_d = 3'(WORD_GAP_UNITS);
          state_d  = S_GAP;
        end else if (!dec_ok) begin
          bad_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          code_d   = CODE_W'(dec_code);
          len_d    = dec_len;
          target_d = dec_code[0] ? 3'(DASH_UNITS) : 3'd1;
          state_d  = S_MARK;
        end
      end
      S_MARK: begin
        if (phase_done) begin
          cyc_d    = '0;
          unit_d   = '0;
          idx_d    = idx_q + 3'd1;
          target_d = ((idx_q + 3'd1) == len_q) ? 3'(CHAR_GAP_UNITS) : 3'd1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_done) begin
          cyc_d  = '0;
          unit_d = '0;
          if (idx_q == len_q) begin
            state_d = S_IDLE;
          end else begin
            target_d = code_q[idx_q] ? 3'(DASH_UNITS) : 3'd1;
            state_d  = S_MARK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    key_d  = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      char_q   <= '0;
      code_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      unit_q   <= '0;
      target_q <= '0;
      cyc_q    <= '0;
      key_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      code_q   <= code_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      unit_q   <= unit_d;
      target_q <= target_d;
      cyc_q    <= cyc_d;
      key_q    <= key_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      bad_q    <= bad_d;
    end
  end

  assign key            = key_q;
  assign busy           = busy_q;
  assign bad_char       = bad_q;
  assign in_if.in_ready = rdy_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4; sample index 0 is the DECODE cycle
// right after the accepting edge, so the key is high from sample 1 onwards.
module tb_morse_keyer;
  localparam int unsigned U = 4;

  logic clk_24 = 1'b0;
  logic rst;
  logic key, busy, bad_char;

  morse_keyer_if bus ();

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .clk_24   (clk_24),
    .rst      (rst),
    .in_if    (bus),
    .key      (key),
    .busy     (busy),
    .bad_char (bad_char)
  );

  always #5 clk_24 = ~clk_24;

  int checks = 0;
  int errors = 0;
  logic key_tr[$], busy_tr[$], rdy_tr[$], bad_tr[$];
  logic exp_k[$], exp_b[$], exp_r[$], exp_x[$];

  task automatic clear_exp();
    exp_k.delete(); exp_b.delete(); exp_r.delete(); exp_x.delete();
  endtask

  // sel: 0 key, 1 busy, 2 in_ready, 3 bad_char
  task automatic add_run(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      case (sel)
        0: exp_k.push_back(v);
        1: exp_b.push_back(v);
        2: exp_r.push_back(v);
        default: exp_x.push_back(v);
      endcase
    end
  endtask

  task automatic send(input logic [6:0] c, input bit hold, input logic [6:0] next_c);
    bit ok = 1'b0;
    @(negedge clk_24);
    bus.ascii_in = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk_24);
    end
    @(posedge clk_24);
    #1;
    bus.ascii_in = next_c;
    if (!hold) bus.in_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL accept_%0h: in_ready got %b expected 1 within 200 cycles", c, ok);
    end
  endtask

  task automatic capture(input int n, input int drop_at);
    key_tr.delete(); busy_tr.delete(); rdy_tr.delete(); bad_tr.delete();
    for (int j = 0; j < n; j++) begin
      @(negedge clk_24);
      key_tr.push_back(key);
      busy_tr.push_back(busy);
      rdy_tr.push_back(bus.in_ready);
      bad_tr.push_back(bad_char);
      if (j == drop_at) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.ascii_in = 7'h00;
    repeat (3) @(negedge clk_24);
    checks++;
    if ({key, busy, bad_char, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_outputs: key/busy/bad/rdy got %b expected 0001", {key, busy, bad_char, bus.in_ready});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_24);
    checks++;
    if ({key, busy, bad_char, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_idle: key/busy/bad/rdy got %b expected 0001", {key, busy, bad_char, bus.in_ready});
    end
  endtask

  task automatic test_single_e();
    int bk = -1, bb = -1, br = -1, bx = -1;
    clear_exp();
    add_run(0, 1'b0, 1); add_run(0, 1'b1, 4); add_run(0, 1'b0, 15);
    add_run(1, 1'b1, 17); add_run(1, 1'b0, 3);
    add_run(2, 1'b0, 17); add_run(2, 1'b1, 3);
    add_run(3, 1'b0, 20);
    send(7'h45, 1'b0, 7'h00);
    capture(20, -1);
    for (int i = 0; i < 20; i++) begin
      if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
      if (bb < 0 && busy_tr[i] !== exp_b[i]) bb = i;
      if (br < 0 && rdy_tr[i] !== exp_r[i]) br = i;
      if (bx < 0 && bad_tr[i] !== exp_x[i]) bx = i;
    end
    checks += 4;
    if (bk >= 0) begin errors++; $display("FAIL e_key: sample %0d got %b expected %b", bk, key_tr[bk], exp_k[bk]); end
    if (bb >= 0) begin errors++; $display("FAIL e_busy: sample %0d got %b expected %b", bb, busy_tr[bb], exp_b[bb]); end
    if (br >= 0) begin errors++; $display("FAIL e_ready: sample %0d got %b expected %b", br, rdy_tr[br], exp_r[br]); end
    if (bx >= 0) begin errors++; $display("FAIL e_bad: sample %0d got %b expected %b", bx, bad_tr[bx], exp_x[bx]); end
  endtask

  task automatic test_lowercase();
    logic [6:0] chars [2];
    chars[0] = 7'h61;
    chars[1] = 7'h41;
    clear_exp();
    add_run(0, 1'b0, 1); add_run(0, 1'b1, 4); add_run(0, 1'b0, 4);
    add_run(0, 1'b1, 12); add_run(0, 1'b0, 15);
    for (int n = 0; n < 2; n++) begin
      int bk = -1, bx = -1;
      send(chars[n], 1'b0, 7'h00);
      capture(36, -1);
      for (int i = 0; i < 36; i++) begin
        if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
        if (bx < 0 && bad_tr[i] !== 1'b0) bx = i;
      end
      checks += 2;
      if (bk >= 0) begin errors++; $display("FAIL a_key_%0h: sample %0d got %b expected %b", chars[n], bk, key_tr[bk], exp_k[bk]); end
      if (bx >= 0) begin errors++; $display("FAIL a_bad_%0h: sample %0d got %b expected 0", chars[n], bx, bad_tr[bx]); end
    end
  endtask

  task automatic test_word_space();
    int bk = -1, bb = -1;
    clear_exp();
    add_run(0, 1'b0, 1);
    for (int e = 0; e < 2; e++) begin add_run(0, 1'b1, 4); add_run(0, 1'b0, 4); end
    add_run(0, 1'b1, 4); add_run(0, 1'b0, 31);
    add_run(1, 1'b1, 33); add_run(1, 1'b0, 1); add_run(1, 1'b1, 17); add_run(1, 1'b0, 1);
    send(7'h53, 1'b1, 7'h20);
    capture(52, 34);
    for (int i = 0; i < 52; i++) begin
      if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
      if (bb < 0 && busy_tr[i] !== exp_b[i]) bb = i;
    end
    checks += 2;
    if (bk >= 0) begin errors++; $display("FAIL space_key: sample %0d got %b expected %b", bk, key_tr[bk], exp_k[bk]); end
    if (bb >= 0) begin errors++; $display("FAIL space_busy: sample %0d got %b expected %b", bb, busy_tr[bb], exp_b[bb]); end
  endtask

  task automatic test_bad_char();
    int bk = -1, bb = -1, br = -1, bx = -1;
    clear_exp();
    add_run(1, 1'b1, 1); add_run(1, 1'b0, 5);
    add_run(2, 1'b0, 1); add_run(2, 1'b1, 5);
    add_run(3, 1'b0, 1); add_run(3, 1'b1, 1); add_run(3, 1'b0, 4);
    send(7'h23, 1'b0, 7'h00);
    capture(6, -1);
    for (int i = 0; i < 6; i++) begin
      if (bk < 0 && key_tr[i] !== 1'b0) bk = i;
      if (bb < 0 && busy_tr[i] !== exp_b[i]) bb = i;
      if (br < 0 && rdy_tr[i] !== exp_r[i]) br = i;
      if (bx < 0 && bad_tr[i] !== exp_x[i]) bx = i;
    end
    checks += 4;
    if (bk >= 0) begin errors++; $display("FAIL hash_key: sample %0d got %b expected 0", bk, key_tr[bk]); end
    if (bb >= 0) begin errors++; $display("FAIL hash_busy: sample %0d got %b expected %b", bb, busy_tr[bb], exp_b[bb]); end
    if (br >= 0) begin errors++; $display("FAIL hash_ready: sample %0d got %b expected %b", br, rdy_tr[br], exp_r[br]); end
    if (bx >= 0) begin errors++; $display("FAIL hash_bad: sample %0d got %b expected %b", bx, bad_tr[bx], exp_x[bx]); end
  endtask

  task automatic test_punct();
    int bk = -1, bx = -1;
    clear_exp();
`ifdef MORSE_PUNCT_EN
    add_run(0, 1'b0, 1);
    for (int e = 0; e < 2; e++) begin
      add_run(0, 1'b1, 4); add_run(0, 1'b0, 4); add_run(0, 1'b1, 12); add_run(0, 1'b0, 4);
    end
    add_run(0, 1'b1, 4); add_run(0, 1'b0, 4); add_run(0, 1'b1, 12); add_run(0, 1'b0, 13);
    add_run(3, 1'b0, 82);
`else
    add_run(0, 1'b0, 6);
    add_run(3, 1'b0, 1); add_run(3, 1'b1, 1); add_run(3, 1'b0, 4);
`endif
    send(7'h2E, 1'b0, 7'h00);
    capture(exp_k.size(), -1);
    for (int i = 0; i < exp_k.size(); i++) begin
      if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
      if (bx < 0 && bad_tr[i] !== exp_x[i]) bx = i;
    end
    checks += 2;
    if (bk >= 0) begin errors++; $display("FAIL period_key: sample %0d got %b expected %b", bk, key_tr[bk], exp_k[bk]); end
    if (bx >= 0) begin errors++; $display("FAIL period_bad: sample %0d got %b expected %b", bx, bad_tr[bx], exp_x[bx]); end
  endtask

  task automatic test_reset_mid();
    int bk = -1;
    send(7'h30, 1'b0, 7'h00);
    capture(23, -1);
    checks++;
    if (key_tr[22] !== 1'b1) begin
      errors++;
      $display("FAIL zero_second_dash: key got %b expected 1", key_tr[22]);
    end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (key !== 1'b0) begin errors++; $display("FAIL async_rst_key: got %b expected 0", key); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b expected 1", bus.in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    @(negedge clk_24);
    rst = 1'b0;
    clear_exp();
    add_run(0, 1'b0, 1);
    for (int e = 0; e < 4; e++) begin add_run(0, 1'b1, 4); add_run(0, 1'b0, 4); end
    add_run(0, 1'b1, 4); add_run(0, 1'b0, 3);
    send(7'h35, 1'b0, 7'h00);
    capture(40, -1);
    for (int i = 0; i < 40; i++) if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
    checks++;
    if (bk >= 0) begin errors++; $display("FAIL five_key: sample %0d got %b expected %b", bk, key_tr[bk], exp_k[bk]); end
    // drain the tail of the '5' character gap
    repeat (12) @(negedge clk_24);
  endtask

  task automatic test_back_to_back();
    int bk = -1;
    clear_exp();
    add_run(0, 1'b0, 1);
    add_run(0, 1'b1, 12); add_run(0, 1'b0, 4); add_run(0, 1'b1, 4); add_run(0, 1'b0, 4);
    add_run(0, 1'b1, 12); add_run(0, 1'b0, 14);
    for (int e = 0; e < 4; e++) begin add_run(0, 1'b1, 12); add_run(0, 1'b0, 4); end
    add_run(0, 1'b1, 4); add_run(0, 1'b0, 13);
    send(7'h4B, 1'b1, 7'h39);
    capture(132, 50);
    for (int i = 0; i < 132; i++) if (bk < 0 && key_tr[i] !== exp_k[i]) bk = i;
    checks++;
    if (bk >= 0) begin errors++; $display("FAIL k9_key: sample %0d got %b expected %b", bk, key_tr[bk], exp_k[bk]); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL k9_ready_end: got %b expected 1", bus.in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_e();
    test_lowercase();
    test_word_space();
    test_bad_char();
    test_punct();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
